// File: rtl/arranque_pkg.sv
// arranque_pkg: shared types and helpers for the partial-ramp motor start chain.
`default_nettype none

package arranque_pkg;

    typedef enum logic [1:0] {
        PARADO   = 2'd0,
        SUBIENDO = 2'd1,
        BAJANDO  = 2'd2,
        ESTABLE  = 2'd3
    } estado_pwm_t;

    localparam int PCT_30  = 30;
    localparam int PCT_50  = 50;
    localparam int PCT_100 = 100;

    // Duty in clock cycles for a percentage of the period, truncated.
    function automatic int duty_de_pct(input int period, input int pct);
        return (period * pct) / 100;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_contador.sv
// pwm_contador: PWM period counter, end-of-period strobe and registered duty compare.
`default_nettype none

module pwm_contador #(
    parameter  int PERIOD = 100,
    localparam int W      = $clog2(PERIOD + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] duty_i,
    output logic         fin_periodo_o,
    output logic         pwm_o
);

    localparam logic [W-1:0] CNT_MAX = W'(PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         pwm_q, pwm_d;

    always_comb begin
        cnt_d = (cnt_q == CNT_MAX) ? '0 : cnt_q + W'(1);
        // cnt never reaches PERIOD, so a full-period duty stays high across the wrap.
        pwm_d = (cnt_q < duty_i);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            pwm_q <= pwm_d;
        end
    end

    assign fin_periodo_o = (cnt_q == CNT_MAX);
    assign pwm_o         = pwm_q;

endmodule

`default_nettype wire

// File: rtl/pwm_rampa_motor.sv
// pwm_rampa_motor: ramps the motor PWM duty towards the selected speed level, one step per period.
// Build option PWM_RAMPA_BAJADA_EN: ramp decreases by STEP too (otherwise decreases jump to target).
`default_nettype none

module pwm_rampa_motor
    import arranque_pkg::*;
#(
    parameter  int PERIOD = 100,
    parameter  int STEP   = 5,
    localparam int W      = $clog2(PERIOD + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         sel_30,
    input  logic         sel_50,
    input  logic         sel_100,
    output logic         pwm_out,
    output logic [W-1:0] duty_actual,
    output logic         en_rampa,
    output logic         err_sel
);

    localparam logic [W-1:0] D30    = W'(duty_de_pct(PERIOD, PCT_30));
    localparam logic [W-1:0] D50    = W'(duty_de_pct(PERIOD, PCT_50));
    localparam logic [W-1:0] D100   = W'(duty_de_pct(PERIOD, PCT_100));
    localparam logic [W-1:0] C_STEP = W'(STEP);

    estado_pwm_t  estado_q, estado_d;
    logic [W-1:0] duty_q, duty_d;
    logic [W-1:0] target_q, target_d;
    logic         err_q, multi_sel;
    logic         fin_periodo;

    pwm_contador #(
        .PERIOD (PERIOD)
    ) u_contador (
        .clk           (clk),
        .reset         (reset),
        .duty_i        (duty_q),
        .fin_periodo_o (fin_periodo),
        .pwm_o         (pwm_out)
    );

    assign multi_sel = (sel_30 & sel_50) | (sel_30 & sel_100) | (sel_50 & sel_100);

    // An illegal multi-level request freezes the target at its last legal value.
    always_comb begin
        target_d = target_q;
        if (!multi_sel) begin
            if (sel_30)       target_d = D30;
            else if (sel_50)  target_d = D50;
            else if (sel_100) target_d = D100;
            else              target_d = '0;
        end
    end

    always_comb begin
        duty_d   = duty_q;
        estado_d = estado_q;
        if (fin_periodo) begin
            // Differences are compared against STEP so the sums never leave W bits.
            if (duty_q < target_d) begin
                duty_d = ((target_d - duty_q) > C_STEP) ? duty_q + C_STEP : target_d;
            end else if (duty_q > target_d) begin
`ifdef PWM_RAMPA_BAJADA_EN
                duty_d = ((duty_q - target_d) > C_STEP) ? duty_q - C_STEP : target_d;
`else
                duty_d = target_d;
`endif
            end

            if (duty_d == target_d)     estado_d = (target_d == '0) ? PARADO : ESTABLE;
            else if (duty_d < target_d) estado_d = SUBIENDO;
            else                        estado_d = BAJANDO;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q <= PARADO;
            duty_q   <= '0;
            target_q <= '0;
            err_q    <= 1'b0;
        end else begin
            estado_q <= estado_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            err_q    <= multi_sel;
        end
    end

    assign duty_actual = duty_q;
    assign en_rampa    = (estado_q == SUBIENDO) || (estado_q == BAJANDO);
    assign err_sel     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_pwm_rampa_motor.sv
// tb_pwm_rampa_motor: directed checks of the ramped PWM stage (PERIOD=100, STEP=5 and STEP=7).
`default_nettype none

module tb_pwm_rampa_motor;

    localparam int PERIOD = 100;
    localparam int W      = $clog2(PERIOD + 1);

    logic         clk = 1'b0;
    logic         reset;
    logic         sel_30, sel_50, sel_100;
    logic         pwm_out;
    logic [W-1:0] duty_actual;
    logic         en_rampa, err_sel;

    logic         sel7_30;
    logic         pwm7_out;
    logic [W-1:0] duty7_actual;
    logic         en7_rampa, err7_sel;

    int n_cmp = 0;
    int n_err = 0;
    int ncyc  = 0;
    int highs;

    always #5 clk = ~clk;

    pwm_rampa_motor #(.PERIOD(PERIOD), .STEP(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .sel_30      (sel_30),
        .sel_50      (sel_50),
        .sel_100     (sel_100),
        .pwm_out     (pwm_out),
        .duty_actual (duty_actual),
        .en_rampa    (en_rampa),
        .err_sel     (err_sel)
    );

    pwm_rampa_motor #(.PERIOD(PERIOD), .STEP(7)) dut7 (
        .clk         (clk),
        .reset       (reset),
        .sel_30      (sel7_30),
        .sel_50      (1'b0),
        .sel_100     (1'b0),
        .pwm_out     (pwm7_out),
        .duty_actual (duty7_actual),
        .en_rampa    (en7_rampa),
        .err_sel     (err7_sel)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges and land on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
        ncyc += n;
    endtask

    // Edge k after reset release updates the duty when k is a multiple of PERIOD.
    task automatic to_boundary();
        cyc(PERIOD - (ncyc % PERIOD));
    endtask

    task automatic count_pwm(input int n);
        highs = 0;
        for (int i = 0; i < n; i++) begin
            cyc(1);
            if (pwm_out) highs++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        ncyc  = 0;
    endtask

    initial begin
        reset = 1'b1; sel_30 = 0; sel_50 = 0; sel_100 = 0; sel7_30 = 0;
        cyc(3);
        chk("rst_pwm",  pwm_out, 0);
        chk("rst_duty", duty_actual, 0);
        chk("rst_en",   en_rampa, 0);
        chk("rst_err",  err_sel, 0);
        reset = 1'b0;
        ncyc  = 0;

        // Ramp up to 30 %; second instance uses STEP=7 and must clamp at 30.
        sel_30 = 1; sel7_30 = 1;
        cyc(1);
        chk("t1_duty_pre", duty_actual, 0);
        chk("t1_en_pre",   en_rampa, 0);
        for (int n = 1; n <= 6; n++) begin
            to_boundary();
            chk($sformatf("t1_duty_b%0d", n), duty_actual, 5 * n);
            chk($sformatf("t1_en_b%0d", n), en_rampa, (n < 6) ? 1 : 0);
            chk($sformatf("t5_duty7_b%0d", n), duty7_actual, (n < 5) ? 7 * n : 30);
            chk($sformatf("t5_en7_b%0d", n), en7_rampa, (n < 5) ? 1 : 0);
        end
        count_pwm(PERIOD);
        chk("t1_highs", highs, 30);
        chk("t1_err", err_sel, 0);

        // 30 -> 100 in 14 boundaries, then a solid high output.
        sel_30 = 0; sel_100 = 1;
        for (int n = 1; n <= 14; n++) begin
            to_boundary();
            chk($sformatf("t2_duty_b%0d", n), duty_actual, 30 + 5 * n);
            chk($sformatf("t2_en_b%0d", n), en_rampa, (n < 14) ? 1 : 0);
        end
        count_pwm(2 * PERIOD);
        chk("t2_highs", highs, 2 * PERIOD);

        // Illegal double selection freezes the target at 100.
        sel_50 = 1;
        chk("t3_err_same", err_sel, 0);
        cyc(1);
        chk("t3_err_set", err_sel, 1);
        to_boundary();
        chk("t3_duty_hold", duty_actual, 100);
        chk("t3_en_hold", en_rampa, 0);
        chk("t3_err_hold", err_sel, 1);
        cyc(10);
        sel_100 = 0;
        chk("t3_err_before", err_sel, 1);
        cyc(1);
        chk("t3_err_clr", err_sel, 0);
`ifdef PWM_RAMPA_BAJADA_EN
        for (int n = 1; n <= 10; n++) begin
            to_boundary();
            chk($sformatf("t3_duty_b%0d", n), duty_actual, 100 - 5 * n);
            chk($sformatf("t3_en_b%0d", n), en_rampa, (n < 10) ? 1 : 0);
        end
`else
        to_boundary();
        chk("t3_duty_jump", duty_actual, 50);
        chk("t3_en_jump", en_rampa, 0);
`endif

        // All levels off: back to zero and a solid low output.
        sel_50 = 0;
`ifdef PWM_RAMPA_BAJADA_EN
        for (int n = 1; n <= 10; n++) begin
            to_boundary();
            chk($sformatf("t4_duty_b%0d", n), duty_actual, 50 - 5 * n);
            chk($sformatf("t4_en_b%0d", n), en_rampa, (n < 10) ? 1 : 0);
        end
`else
        to_boundary();
        chk("t4_duty_jump", duty_actual, 0);
        chk("t4_en_jump", en_rampa, 0);
`endif
        cyc(1);
        count_pwm(2 * PERIOD);
        chk("t4_highs", highs, 0);

        // Reset mid-ramp while the output is high (cnt 10, duty 15).
        do_reset();
        sel_30 = 1;
        for (int n = 1; n <= 3; n++) to_boundary();
        cyc(10);
        chk("t6_duty_pre", duty_actual, 15);
        chk("t6_pwm_pre", pwm_out, 1);
        chk("t6_en_pre", en_rampa, 1);
        #1 reset = 1'b1;
        #1;
        chk("t6_pwm_async", pwm_out, 0);
        chk("t6_duty_async", duty_actual, 0);
        chk("t6_en_async", en_rampa, 0);
        @(negedge clk);
        cyc(2);
        reset = 1'b0;
        ncyc  = 0;
        to_boundary();
        chk("t6_duty_restart", duty_actual, 5);
        chk("t6_en_restart", en_rampa, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
